// File: rtl/arith_pkg.sv
// arith_pkg: shared definitions for the arithmetic unit.
//   - state_t         : operand_sequencer state encodings (also driven onto o_stage)
//   - OP_*            : opcode constants understood by the arithmetic units
//   - DEF_DATA_W/OP_W : default operand and opcode widths
//   - canon_sm()      : sign-magnitude zero canonicalisation at the default width
package arith_pkg;

    localparam int DEF_DATA_W = 3;
    localparam int DEF_OP_W   = 3;

    typedef enum logic [1:0] {
        S_A     = 2'b00,
        S_B     = 2'b01,
        S_OP    = 2'b10,
        S_VALID = 2'b11
    } state_t;

    localparam logic [DEF_OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [DEF_OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [DEF_OP_W-1:0] OP_MUL = 3'd2;
    localparam logic [DEF_OP_W-1:0] OP_DIV = 3'd3;
    localparam logic [DEF_OP_W-1:0] OP_REM = 3'd4;
    localparam logic [DEF_OP_W-1:0] OP_NEG = 3'd5;
    localparam logic [DEF_OP_W-1:0] OP_ABS = 3'd6;
    localparam logic [DEF_OP_W-1:0] OP_CMP = 3'd7;

    // Negative zero (sign set, magnitude zero) collapses to all zeros so
    // every consumer sees a single encoding of zero.
    function automatic logic [DEF_DATA_W-1:0] canon_sm(input logic [DEF_DATA_W-1:0] x);
        if (x[DEF_DATA_W-2:0] == '0)
            return '0;
        return x;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// rise_detect: one-cycle pulse on a rising edge of a level input.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset; delayed bit loads RST_VAL
//   d     - level input (already synchronised)
//   pulse - d & ~d_q, combinational from d and the delayed bit
// With RST_VAL = 1 a level held high through reset release is not seen as
// an edge.
module rise_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            d_q <= RST_VAL;
        else
            d_q <= d;
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/operand_sequencer.sv
// operand_sequencer: captures operand A, operand B and the opcode in turn
// from shared switches, one per Enter press, then presents the set.
// Ports:
//   i_clk    - clock
//   i_rst_n  - synchronous active-low reset
//   i_sw     - shared switches (operand, or opcode in the low OP_W bits)
//   i_enter  - Enter button level (debounced, synchronised)
//   i_clear  - synchronous abort, active-high, below reset in priority
//   i_ready  - consumer ready
//   o_A/o_B  - captured sign-magnitude operands (negative zero canonicalised)
//   o_op     - captured opcode
//   o_valid  - operand set presented
//   o_stage  - current state encoding (status LEDs / debug)
//   o_bz     - registered flag: magnitude of o_B is zero
//
// Handshake: a transfer happens on any rising edge where o_valid and
// i_ready are both 1. o_valid never drops without a transfer (except on
// reset/clear), and o_A/o_B/o_op/o_bz are stable whenever o_valid is 1.
// i_ready is ignored while o_valid is 0.
module operand_sequencer
    import arith_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OP_W   = DEF_OP_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_sw,
    input  logic              i_enter,
    input  logic              i_clear,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_A,
    output logic [DATA_W-1:0] o_B,
    output logic [OP_W-1:0]   o_op,
    output logic              o_valid,
    output logic [1:0]        o_stage,
    output logic              o_bz
);

    state_t            state_q;
    state_t            state_d;
    logic              enter_pulse;
    logic              sw_mag_zero;
    logic [DATA_W-1:0] sw_canon;

    // Delayed Enter resets to 1 so a button held through reset is ignored.
    // It is not affected by i_clear.
    rise_detect #(
        .RST_VAL (1'b1)
    ) u_enter_edge (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .d     (i_enter),
        .pulse (enter_pulse)
    );

    assign sw_mag_zero = (i_sw[DATA_W-2:0] == '0);
    assign sw_canon    = sw_mag_zero ? '0 : i_sw;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (i_clear) begin
            state_d = S_A;
        end else begin
            case (state_q)
                S_A:     if (enter_pulse) state_d = S_B;
                S_B:     if (enter_pulse) state_d = S_OP;
                S_OP:    if (enter_pulse) state_d = S_VALID;
                S_VALID: if (i_ready)     state_d = S_A;
                default:                  state_d = S_A;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            state_q <= S_A;
        else
            state_q <= state_d;
    end

    // Capture registers; each loads only on its own state's Enter pulse,
    // so they hold through S_VALID and after a transfer.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            o_A  <= '0;
            o_B  <= '0;
            o_op <= '0;
            o_bz <= 1'b1;
        end else if (enter_pulse) begin
            case (state_q)
                S_A: o_A <= sw_canon;
                S_B: begin
                    o_B  <= sw_canon;
                    o_bz <= sw_mag_zero;
                end
                S_OP:    o_op <= i_sw[OP_W-1:0];
                default: ;
            endcase
        end
    end

    assign o_valid = (state_q == S_VALID);
    assign o_stage = state_q;

endmodule

// File: tb/tb_operand_sequencer.sv
module tb_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] sw;
    logic       enter;
    logic       clear;
    logic       ready;
    logic [2:0] a_o, b_o, op_o;
    logic       valid_o;
    logic [1:0] stage_o;
    logic       bz_o;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int xfer_cnt = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    operand_sequencer #(.DATA_W(3), .OP_W(3)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_sw    (sw),
        .i_enter (enter),
        .i_clear (clear),
        .i_ready (ready),
        .o_A     (a_o),
        .o_B     (b_o),
        .o_op    (op_o),
        .o_valid (valid_o),
        .o_stage (stage_o),
        .o_bz    (bz_o)
    );

    // Transfer monitor: valid & ready sampled at the active edge.
    always @(posedge clk) begin
        if (rst_n === 1'b1 && valid_o === 1'b1 && ready === 1'b1)
            xfer_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Rising edge on enter; capture lands on the first edge.
    task automatic press(input logic [2:0] v);
        sw    = v;
        enter = 1'b1;
        step();
        enter = 1'b0;
        step();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; enter = 1'b1; clear = 1'b0; ready = 1'b0; sw = 3'b011;
        step(); step();
        rst_n = 1'b1;
        repeat (5) step();
        chk_cnt++; if (stage_o !== 2'b00) $display("FAIL reset_stage got=%b exp=00", stage_o); else pass_cnt++;
        chk_cnt++; if (a_o !== 3'b000) $display("FAIL reset_A got=%b exp=000", a_o); else pass_cnt++;
        chk_cnt++; if (b_o !== 3'b000 || op_o !== 3'b000) $display("FAIL reset_B_op got=%b/%b exp=000/000", b_o, op_o); else pass_cnt++;
        chk_cnt++; if (valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid_o); else pass_cnt++;
        chk_cnt++; if (bz_o !== 1'b1) $display("FAIL reset_bz got=%b exp=1", bz_o); else pass_cnt++;
        enter = 1'b0;
        step();
    endtask

    task automatic test_capture();
        bit stable_ok;
        press(3'b011);
        press(3'b101);
        chk_cnt++; if (stage_o !== 2'b10) $display("FAIL cap_stage_op got=%b exp=10", stage_o); else pass_cnt++;
        sw = 3'b100; enter = 1'b1;
        chk_cnt++; if (valid_o !== 1'b0) $display("FAIL cap_valid_early got=%b exp=0", valid_o); else pass_cnt++;
        step();
        enter = 1'b0;
        chk_cnt++; if (valid_o !== 1'b1 || stage_o !== 2'b11) $display("FAIL cap_valid_rise got=%b/%b exp=1/11", valid_o, stage_o); else pass_cnt++;
        chk_cnt++; if (a_o !== 3'b011 || b_o !== 3'b101 || op_o !== 3'b100) $display("FAIL cap_values got=%b/%b/%b exp=011/101/100", a_o, b_o, op_o); else pass_cnt++;
        chk_cnt++; if (bz_o !== 1'b0) $display("FAIL cap_bz got=%b exp=0", bz_o); else pass_cnt++;
        stable_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (valid_o !== 1'b1 || a_o !== 3'b011 || b_o !== 3'b101 || op_o !== 3'b100 || bz_o !== 1'b0)
                stable_ok = 1'b0;
        end
        chk_cnt++; if (stable_ok !== 1'b1) $display("FAIL cap_stable got=%b exp=1", stable_ok); else pass_cnt++;
    endtask

    task automatic test_valid_ignore_enter();
        int x0;
        press(3'b111);
        chk_cnt++; if (a_o !== 3'b011 || op_o !== 3'b100 || valid_o !== 1'b1) $display("FAIL vld_enter_ignored got=%b/%b/%b exp=011/100/1", a_o, op_o, valid_o); else pass_cnt++;
        x0 = xfer_cnt;
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk_cnt++; if (xfer_cnt !== x0 + 1) $display("FAIL vld_xfer_count got=%0d exp=%0d", xfer_cnt, x0 + 1); else pass_cnt++;
        chk_cnt++; if (valid_o !== 1'b0 || stage_o !== 2'b00) $display("FAIL vld_after_xfer got=%b/%b exp=0/00", valid_o, stage_o); else pass_cnt++;
        chk_cnt++; if (a_o !== 3'b011 || b_o !== 3'b101 || op_o !== 3'b100 || bz_o !== 1'b0) $display("FAIL vld_hold_after got=%b/%b/%b/%b exp=011/101/100/0", a_o, b_o, op_o, bz_o); else pass_cnt++;
        // i_ready outside S_VALID has no effect
        ready = 1'b1;
        step(); step();
        ready = 1'b0;
        chk_cnt++; if (stage_o !== 2'b00 || xfer_cnt !== x0 + 1) $display("FAIL ready_idle got=%b/%0d exp=00/%0d", stage_o, xfer_cnt, x0 + 1); else pass_cnt++;
    endtask

    task automatic test_neg_zero();
        press(3'b100);
        press(3'b100);
        chk_cnt++; if (a_o !== 3'b000 || b_o !== 3'b000) $display("FAIL negzero_AB got=%b/%b exp=000/000", a_o, b_o); else pass_cnt++;
        chk_cnt++; if (bz_o !== 1'b1) $display("FAIL negzero_bz got=%b exp=1", bz_o); else pass_cnt++;
        press(3'b011);
        chk_cnt++; if (op_o !== 3'b011 || valid_o !== 1'b1) $display("FAIL negzero_op got=%b/%b exp=011/1", op_o, valid_o); else pass_cnt++;
        ready = 1'b1; step(); ready = 1'b0;
        chk_cnt++; if (stage_o !== 2'b00) $display("FAIL negzero_xfer got=%b exp=00", stage_o); else pass_cnt++;
    endtask

    task automatic test_hold();
        sw = 3'b001; enter = 1'b1;
        step();
        sw = 3'b010;
        repeat (4) step();
        chk_cnt++; if (a_o !== 3'b001 || stage_o !== 2'b01) $display("FAIL hold_one_capture got=%b/%b exp=001/01", a_o, stage_o); else pass_cnt++;
        enter = 1'b0;
        step();
    endtask

    task automatic test_clear_with_enter();
        press(3'b110);
        chk_cnt++; if (b_o !== 3'b110 || bz_o !== 1'b0 || stage_o !== 2'b10) $display("FAIL clr_setup got=%b/%b/%b exp=110/0/10", b_o, bz_o, stage_o); else pass_cnt++;
        sw = 3'b011; enter = 1'b1; clear = 1'b1;
        step();
        clear = 1'b0; enter = 1'b0;
        step();
        chk_cnt++; if (stage_o !== 2'b00 || valid_o !== 1'b0) $display("FAIL clr_stage got=%b/%b exp=00/0", stage_o, valid_o); else pass_cnt++;
        chk_cnt++; if (a_o !== 3'b000 || b_o !== 3'b000 || op_o !== 3'b000 || bz_o !== 1'b1) $display("FAIL clr_values got=%b/%b/%b/%b exp=000/000/000/1", a_o, b_o, op_o, bz_o); else pass_cnt++;
        press(3'b010);
        chk_cnt++; if (a_o !== 3'b010 || stage_o !== 2'b01) $display("FAIL clr_resume got=%b/%b exp=010/01", a_o, stage_o); else pass_cnt++;
    endtask

    task automatic test_ready_clear();
        int x0;
        press(3'b111);
        press(3'b001);
        chk_cnt++; if (valid_o !== 1'b1 || b_o !== 3'b111 || op_o !== 3'b001) $display("FAIL rc_setup got=%b/%b/%b exp=1/111/001", valid_o, b_o, op_o); else pass_cnt++;
        x0 = xfer_cnt;
        ready = 1'b1; clear = 1'b1;
        step();
        ready = 1'b0; clear = 1'b0;
        chk_cnt++; if (xfer_cnt !== x0 + 1) $display("FAIL rc_xfer got=%0d exp=%0d", xfer_cnt, x0 + 1); else pass_cnt++;
        chk_cnt++; if (stage_o !== 2'b00 || a_o !== 3'b000 || b_o !== 3'b000 || op_o !== 3'b000 || bz_o !== 1'b1) $display("FAIL rc_cleared got=%b/%b/%b/%b/%b exp=00/000/000/000/1", stage_o, a_o, b_o, op_o, bz_o); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        press(3'b111);
        chk_cnt++; if (stage_o !== 2'b01 || a_o !== 3'b111) $display("FAIL rstmid_setup got=%b/%b exp=01/111", stage_o, a_o); else pass_cnt++;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk_cnt++; if (stage_o !== 2'b00 || a_o !== 3'b000 || b_o !== 3'b000 || op_o !== 3'b000 || bz_o !== 1'b1 || valid_o !== 1'b0) $display("FAIL rstmid_values got=%b/%b/%b/%b/%b/%b exp=00/000/000/000/1/0", stage_o, a_o, b_o, op_o, bz_o, valid_o); else pass_cnt++;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_capture();
        test_valid_ignore_enter();
        test_neg_zero();
        test_hold();
        test_clear_with_enter();
        test_ready_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
